// File: rtl/vector_stream_driver.sv
// Replays a stored instruction program onto a valid/pop stream with per-entry bubbles.
// Optional VSTREAM_DRIVER_LOOP_EN adds loop_i to restart the program instead of finishing.
module vector_stream_driver #(
    parameter int DEPTH            = 64,
    parameter int DLY_W            = 8,
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES     = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1),
    localparam int RW = $clog2(VECTOR_REGISTERS),
    localparam int VW = $clog2(VECTOR_LANES + 1),
    localparam int IW = 8 + 3 * RW + VW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we_i,
    input  logic [AW-1:0]    prog_addr_i,
    input  logic [IW-1:0]    prog_instr_i,
    input  logic [DLY_W-1:0] prog_delay_i,
    input  logic [LW-1:0]    len_i,
    input  logic             start_i,
    input  logic             abort_i,
`ifdef VSTREAM_DRIVER_LOOP_EN
    input  logic             loop_i,
`endif
    output logic             valid_o,
    output logic [IW-1:0]    instr_o,
    input  logic             pop_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      issued_o
);

    typedef struct packed {
        logic          valid;
        logic          use_mask;
        logic [5:0]    opcode;
        logic [RW-1:0] vd;
        logic [RW-1:0] vs1;
        logic [RW-1:0] vs2;
        logic [VW-1:0] vl;
    } to_vector_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DELAY, DONE} state_t;

    state_t           state, next;
    logic [AW-1:0]    head, nhead;
    logic [LW-1:0]    len;
    logic [DLY_W-1:0] count;
    logic [DLY_W-1:0] cur_dly;
    logic [31:0]      issued;
    logic             last;
    to_vector_t       cur, outv;

    logic [IW-1:0]    imem [DEPTH];
    logic [DLY_W-1:0] dmem [DEPTH];

    logic idle_ok, start_go, fire, at_last, loop_go, dly_end;

    assign idle_ok  = (state == IDLE) || (state == DONE);
    assign start_go = idle_ok && start_i && !abort_i;
    assign fire     = (state == ISSUE) && pop_i && !abort_i;
    assign at_last  = LW'(head) == len - LW'(1);
    assign nhead    = at_last ? '0 : head + AW'(1);
    assign dly_end  = count <= DLY_W'(1);

`ifdef VSTREAM_DRIVER_LOOP_EN
    assign loop_go = loop_i;
`else
    assign loop_go = 1'b0;
`endif

    // The program store is writable only while nothing is being issued.
    always_ff @(posedge clk) begin
        if (prog_we_i && idle_ok) begin
            imem[prog_addr_i] <= prog_instr_i;
            dmem[prog_addr_i] <= prog_delay_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        if (abort_i) begin
            next = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start_i) next = (len_i != '0) ? ISSUE : DONE;
                end
                ISSUE: begin
                    if (pop_i) begin
                        if (cur_dly != '0) next = DELAY;
                        else if (at_last)  next = loop_go ? ISSUE : DONE;
                    end
                end
                DELAY: begin
                    if (dly_end) next = (last && !loop_go) ? DONE : ISSUE;
                end
                default: next = IDLE;
            endcase
        end
    end

    // The head entry is captured into cur so later store writes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            len     <= '0;
            count   <= '0;
            cur_dly <= '0;
            issued  <= '0;
            last    <= 1'b0;
            cur     <= '0;
        end else if (start_go) begin
            len     <= len_i;
            head    <= '0;
            issued  <= '0;
            cur     <= imem[AW'(0)];
            cur_dly <= dmem[AW'(0)];
        end else if (fire) begin
            issued  <= issued + 32'd1;
            head    <= nhead;
            last    <= at_last;
            count   <= cur_dly;
            cur     <= imem[nhead];
            cur_dly <= dmem[nhead];
        end else if (state == DELAY && !abort_i) begin
            count   <= count - DLY_W'(1);
        end
    end

    always_comb begin
        valid_o       = (state == ISSUE);
        busy_o        = (state == ISSUE) || (state == DELAY);
        done_o        = (state == DONE);
        outv          = cur;
        outv.valid    = valid_o;
        outv.use_mask = 1'b0;
    end

    assign instr_o  = outv;
    assign issued_o = issued;

endmodule

// File: tb/tb_vector_stream_driver.sv
// Directed bench for vector_stream_driver (default parameters).
// Define VSTREAM_DRIVER_LOOP_EN for both files to cover the loop option.
module tb_vector_stream_driver;

    typedef struct packed {
        logic       valid;
        logic       use_mask;
        logic [5:0] opcode;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [3:0] vl;
    } to_vector_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [26:0] prog_instr;
    logic [7:0]  prog_delay;
    logic [6:0]  len;
    logic        start;
    logic        abort;
    logic        valid;
    logic [26:0] instr;
    logic        pop;
    logic        busy;
    logic        done;
    logic [31:0] issued;
`ifdef VSTREAM_DRIVER_LOOP_EN
    logic        loop_en;
`endif

    int errors = 0;
    int checks = 0;
    int n;
    to_vector_t mem [4];

    always #5 clk = ~clk;

    vector_stream_driver dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we_i    (prog_we),
        .prog_addr_i  (prog_addr),
        .prog_instr_i (prog_instr),
        .prog_delay_i (prog_delay),
        .len_i        (len),
        .start_i      (start),
        .abort_i      (abort),
`ifdef VSTREAM_DRIVER_LOOP_EN
        .loop_i       (loop_en),
`endif
        .valid_o      (valid),
        .instr_o      (instr),
        .pop_i        (pop),
        .busy_o       (busy),
        .done_o       (done),
        .issued_o     (issued)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic to_vector_t ent(input int i);
        to_vector_t t;
        t.valid    = 1'b0;
        t.use_mask = 1'b1;
        t.opcode   = 6'(i * 5 + 3);
        t.vd       = 5'(i + 1);
        t.vs1      = 5'(i + 7);
        t.vs2      = 5'(31 - i);
        t.vl       = 4'(i % 9);
        return t;
    endfunction

    function automatic logic [31:0] want(input to_vector_t t);
        t.valid    = 1'b1;
        t.use_mask = 1'b0;
        return 32'(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input to_vector_t t, input int d);
        prog_we    = 1'b1;
        prog_addr  = 6'(a);
        prog_instr = t;
        prog_delay = 8'(d);
        step();
        prog_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_instr = '0;
        prog_delay = '0; len = '0; start = 1'b0; abort = 1'b0; pop = 1'b0;
`ifdef VSTREAM_DRIVER_LOOP_EN
        loop_en = 1'b0;
`endif
        step();
        step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_issued", issued, 32'd0);
        chk("rst_ivalid", 32'(instr[26]), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            mem[i] = ent(i);
            wr(i, mem[i], 0);
        end

        // back-to-back issue of four entries
        len = 7'd4; start = 1'b1; pop = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_valid", 32'(valid), 32'd1);
            chk("b2b_instr", 32'(instr), want(mem[i]));
            step();
        end
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_issued", issued, 32'd4);
        chk("b2b_valid_end", 32'(valid), 32'd0);
        pop = 1'b0;

        // three bubbles after entry 1
        wr(1, mem[1], 3);
        len = 7'd3; start = 1'b1; pop = 1'b1;
        step();
        start = 1'b0;
        chk("dly_e0", 32'(instr), want(mem[0]));
        step();
        chk("dly_e1", 32'(instr), want(mem[1]));
        step();
        chk("dly_busy", 32'(busy), 32'd1);
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("dly_bubbles", 32'(n), 32'd3);
        chk("dly_e2", 32'(instr), want(mem[2]));
        step();
        chk("dly_done", 32'(done), 32'd1);
        chk("dly_issued", issued, 32'd3);
        pop = 1'b0;
        wr(1, mem[1], 0);

        // stall with pop low
        len = 7'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_instr", 32'(instr), want(mem[0]));
            chk("stall_issued", issued, 32'd0);
            step();
        end
        pop = 1'b1;
        step();
        chk("stall_pop1", issued, 32'd1);
        chk("stall_e1", 32'(instr), want(mem[1]));
        step();
        chk("stall_pop2", issued, 32'd2);
        chk("stall_e2", 32'(instr), want(mem[2]));

        // abort beats pop and start at head 2
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0; pop = 1'b0;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_issued", issued, 32'd2);
        step();
        chk("abort_idle", 32'(valid), 32'd0);

        // zero-length program; pop while not valid is ignored
        len = 7'd0; start = 1'b1; pop = 1'b1;
        step();
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_valid", 32'(valid), 32'd0);
        chk("len0_issued", issued, 32'd0);
        step();
        chk("len0_valid2", 32'(valid), 32'd0);
        chk("len0_popign", issued, 32'd0);
        pop = 1'b0;

        // writes while issuing are dropped
        len = 7'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("wp_valid", 32'(valid), 32'd1);
        wr(0, ent(9), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        len = 7'd1; start = 1'b1; pop = 1'b1;
        step();
        start = 1'b0;
        chk("wp_instr", 32'(instr), want(mem[0]));
        step();
        chk("wp_done", 32'(done), 32'd1);
        pop = 1'b0;

        // write in DONE takes effect at the next start
        mem[0] = ent(9);
        wr(0, mem[0], 0);
        chk("wd_valid", 32'(valid), 32'd0);
        chk("wd_done", 32'(done), 32'd1);
        len = 7'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("wd_instr", 32'(instr), want(mem[0]));

        // asynchronous reset mid-issue
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("arst_idle", 32'(valid), 32'd0);
        chk("arst_done", 32'(done), 32'd0);

`ifdef VSTREAM_DRIVER_LOOP_EN
        loop_en = 1'b1; len = 7'd2; start = 1'b1; pop = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("loop_instr", 32'(instr), want(mem[k % 2]));
            step();
        end
        chk("loop_issued", issued, 32'd4);
        chk("loop_valid", 32'(valid), 32'd1);
        abort = 1'b1; loop_en = 1'b0;
        step();
        abort = 1'b0; pop = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_stream_driver.md
VECTOR_STREAM_DRIVER -- requirements
Module: vector_stream_driver

Interface
REQ-001 SHALL provide parameters: DEPTH, default 64, number of program entries; DLY_W, default 8, delay field width; VECTOR_REGISTERS, default 32; VECTOR_LANES, default 8.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- prog_we_i  in  1  program write strobe.
- prog_addr_i  in  $clog2(DEPTH)  write address.
- prog_instr_i  in  to_vector  instruction to store.
- prog_delay_i  in  DLY_W  bubble cycles after this entry.
- len_i  in  $clog2(DEPTH+1)  program length, sampled on start.
- start_i  in  1  begin issuing.
- abort_i  in  1  stop and return to IDLE.
- valid_o  out  1  instr_o valid.
- instr_o  out  to_vector  instruction at head.
- pop_i  in  1  consumer accepts instr_o.
- busy_o  out  1  state is ISSUE or DELAY.
- done_o  out  1  state is DONE.
- issued_o  out  32  instructions accepted since last start.

Function
REQ-004 SHALL hold a DEPTH-entry program store (instruction plus delay); prog_we_i writes it only in IDLE or DONE, and is ignored in other states.
REQ-005 SHALL implement FSM states IDLE, ISSUE, DELAY, DONE.
REQ-006 IDLE/DONE + start_i: latch len_i, set head=0, clear issued_o; next state ISSUE if len_i>0, else DONE.
REQ-007 ISSUE: valid_o=1; instr_o = store[head] with instr_o.valid=1 and use_mask=0.
- instr_o stays stable while valid_o=1 and pop_i=0.
REQ-008 ISSUE + pop_i: increment issued_o and head.
- If delay[head]>0: go to DELAY with count=delay[head].
- Else if head==len-1: go to DONE.
- Else: stay in ISSUE, so back-to-back issue is one instruction per cycle.
REQ-009 DELAY: valid_o=0 and count decrements each cycle. When count reaches 1, go to ISSUE, or to DONE if the popped entry was the last.
REQ-010 pop_i while valid_o=0 SHALL be ignored.
REQ-011 abort_i in any state: IDLE next cycle. Abort beats pop_i and start_i in the same cycle; the pop is not counted.
REQ-012 A write to the address currently at head during IDLE/DONE SHALL have no effect on outputs until the next start.
REQ-013 issued_o wraps modulo 2^32.
REQ-014 When valid_o=0, instr_o.valid SHALL be 0; other instr_o fields are don't-care.

Reset
REQ-015 While rst is asserted: state=IDLE, head=0, count=0, issued_o=0, valid_o=0, busy_o=0, done_o=0.
- Program store contents are not reset.
REQ-016 Reset asserted mid-ISSUE or mid-DELAY SHALL drop valid_o within the same cycle (asynchronous).

Configuration
REQ-017 Macro VSTREAM_DRIVER_LOOP_EN.
- When defined: add input loop_i (1 bit). If loop_i=1 at the point where DONE would be entered, go to ISSUE with head=0 instead; issued_o keeps counting.
- When undefined: no loop_i port; the program always terminates in DONE.

Verification
REQ-018 Load 4 entries with delay 0, len_i=4, start, pop_i held 1 -> valid_o high 4 consecutive cycles, then done_o=1, issued_o=4.
REQ-019 Entry 1 with delay=3, len_i=3, pop_i held 1 -> exactly 3 valid_o=0 cycles between issue of entry 1 and entry 2.
REQ-020 pop_i=0 for 5 cycles in ISSUE -> instr_o unchanged and valid_o=1 throughout, issued_o unchanged.
REQ-021 abort_i together with pop_i at head=2 -> IDLE next cycle, issued_o=2, valid_o=0.
REQ-022 len_i=0 + start -> done_o=1 next cycle, valid_o never asserted.
REQ-023 With VSTREAM_DRIVER_LOOP_EN and loop_i=1, len_i=2 -> instruction order 0,1,0,1 and issued_o=4 after 4 pops.
